clk_freq_monitor: RTL and testbench
===================================

// Module: clk_freq_monitor
// PURPOSE
//  Consumer-side check on the PLL: runs on the PLL output clock and measures a
//  slower clock (e.g. the 27 MHz crystal) sampled as data. Counts rising edges
//  per fixed gate window, compares the count to an expected value +/- tolerance
//  and asserts `locked` after consecutive good windows. Feeds reset sequencing/status LED.
// PARAMETERS
//  GATE_CYCLES   72000  clk cycles per measurement window (1 ms at 72 MHz)
//  CNT_W         17     width of edge counter/count output
//  EXP_COUNT     27000  expected meas_in rising edges per window
//  TOL           27     allowed |count-EXP_COUNT| for an in-range window
//  LOCK_WINDOWS  4      consecutive in-range windows required to assert locked
// PORTS
//  clk          in   1      measuring clock (PLL clkout); f(meas_in) < f(clk)/2
//  rst_n        in   1      async active-low reset
//  meas_in      in   1      clock under test, asynchronous, treated as data
//  enable       in   1      level; high = measure continuously
//  count        out  CNT_W  edge count of last completed window
//  count_valid  out  1      1-cycle pulse when count updates
//  in_range     out  1      last completed window within tolerance
//  locked       out  1      LOCK_WINDOWS consecutive in-range windows seen
//  lost         out  1      sticky loss-of-lock (only with CLK_MON_STICKY_EN)
//  lost_clr     in   1      clears lost (only with CLK_MON_STICKY_EN)
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; gate/edge/lock counters 0.
//  - meas_in -> 2-FF sync -> rise = sync & ~sync_d (3-cycle latency, 1-cycle pulse).
//  - FSM IDLE/MEASURE/REPORT:
//    IDLE: enable=1 -> MEASURE; gate <= GATE_CYCLES-1, edge_cnt <= 0.
//    MEASURE: rise -> edge_cnt+1, saturating at all-ones; gate decrements;
//      gate==0 -> REPORT (rise on that cycle is counted).
//      enable=0 -> IDLE next cycle: no count_valid; in_range, locked, lock_cnt <= 0;
//      count holds.
//    REPORT (1 cycle): count <= edge_cnt; count_valid=1;
//      in_range <= |edge_cnt-EXP_COUNT| <= TOL (signed, CNT_W+1 bits);
//      in-range: lock_cnt saturating +1; locked <= 1 when new lock_cnt >= LOCK_WINDOWS;
//      out-of-range: lock_cnt <= 0, locked <= 0 in same update.
//      rise in REPORT seeds next window: edge_cnt <= rise?1:0.
//      Next: enable ? MEASURE (gate reloaded) : IDLE.
//  - Window length exactly GATE_CYCLES+1 clk (MEASURE + REPORT), no dead cycles.
//  - meas_in stuck: count=0, in_range=0, locked drops at end of that window.
//  - Async reset mid-window: everything returns to reset values immediately.
// CONFIGURATION
//  CLK_MON_STICKY_EN defined: `lost` sets on any locked 1->0 transition
//    (out-of-range or enable drop); lost_clr clears it; set wins over
//    simultaneous clear.
//  Undefined: lost tied 0, lost_clr ignored, no sticky flop.
// STRUCTURE
//  clk_mon_pkg: FSM state encoding (IDLE/MEASURE/REPORT), abs-diff function,
//    lock counter width = $clog2(LOCK_WINDOWS+1).
//  Sub-module clk_mon_sync_edge: 2-FF synchronizer + rising-edge pulse.
// TESTING (GATE_CYCLES=64, EXP_COUNT=16, TOL=1, LOCK_WINDOWS=2)
//  1 meas_in period 4 clk, enable=1 -> count_valid every 65 clk, count 16..17,
//    in_range=1; locked=1 at 2nd count_valid.
//  2 Locked, then meas_in period 8 -> next count 8..9, in_range=0, locked=0 on
//    that pulse; lost=1 if CLK_MON_STICKY_EN.
//  3 meas_in held 0 -> count=0, in_range=0, locked=0.
//  4 enable dropped mid-window -> no count_valid, locked=0 next cycle, count
//    unchanged; re-enable -> fresh 65-cycle window.
//  5 rst_n low mid-window -> all outputs 0 asynchronously; recovery per test 1.
//  6 CLK_MON_STICKY_EN: lost_clr with simultaneous lock loss -> lost stays 1;
//    later lost_clr alone -> lost=0.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared state encoding and helpers for the clock frequency monitor
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } mon_state_e;

  function automatic int lock_cnt_width(input int windows);
    return (windows < 1) ? 1 : $clog2(windows + 1);
  endfunction

  function automatic int gate_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Both operands are zero-extended edge counts, so an unsigned compare-and-subtract
  // is equivalent to the signed difference magnitude.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/clk_mon_sync_edge.sv
// rtl/clk_mon_sync_edge.sv - two-flop synchronizer with a one-cycle rising-edge pulse
module clk_mon_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic sync_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_d_q <= 1'b0;
    end else begin
      meta_q   <= async_i;
      sync_q   <= meta_q;
      sync_d_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~sync_d_q;

endmodule

// File: rtl/clk_freq_monitor.sv
// rtl/clk_freq_monitor.sv - gated edge counter with tolerance check and lock detection
// Optional sticky loss-of-lock flag enabled by defining CLK_MON_STICKY_EN.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = 72000,
  parameter int CNT_W        = 17,
  parameter int EXP_COUNT    = 27000,
  parameter int TOL          = 27,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             meas_in,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             count_valid,
  output logic             in_range,
  output logic             locked,
  output logic             lost,
  input  logic             lost_clr
);

  localparam int GW  = gate_width(GATE_CYCLES);
  localparam int LCW = lock_cnt_width(LOCK_WINDOWS);
  localparam logic [GW-1:0]  GATE_RELOAD = GW'(GATE_CYCLES - 1);
  localparam logic [LCW-1:0] LOCK_TGT    = LCW'(LOCK_WINDOWS);

  mon_state_e       state_q;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [LCW-1:0]   lock_cnt_q;
  logic [CNT_W-1:0] count_q;
  logic             count_valid_q;
  logic             in_range_q;
  logic             locked_q;

  logic             rise;
  logic             in_tol;
  logic [CNT_W-1:0] edge_cnt_inc;
  logic [LCW-1:0]   lock_cnt_inc;

  clk_mon_sync_edge u_sync_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (meas_in),
    .rise_o  (rise)
  );

  assign edge_cnt_inc = (&edge_cnt_q) ? edge_cnt_q : edge_cnt_q + 1'b1;
  assign lock_cnt_inc = (lock_cnt_q >= LOCK_TGT) ? lock_cnt_q : lock_cnt_q + 1'b1;
  assign in_tol       = abs_diff(32'(edge_cnt_q), 32'(EXP_COUNT)) <= 32'(TOL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gate_q        <= '0;
      edge_cnt_q    <= '0;
      lock_cnt_q    <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      in_range_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q    <= ST_MEASURE;
            gate_q     <= GATE_RELOAD;
            edge_cnt_q <= '0;
          end
        end
        ST_MEASURE: begin
          if (!enable) begin
            state_q    <= ST_IDLE;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
          end else begin
            if (rise) edge_cnt_q <= edge_cnt_inc;
            if (gate_q == '0) state_q <= ST_REPORT;
            else              gate_q  <= gate_q - 1'b1;
          end
        end
        ST_REPORT: begin
          count_q       <= edge_cnt_q;
          count_valid_q <= 1'b1;
          in_range_q    <= in_tol;
          if (in_tol) begin
            lock_cnt_q <= lock_cnt_inc;
            locked_q   <= (lock_cnt_inc >= LOCK_TGT);
          end else begin
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
          end
          // An edge landing on the report cycle belongs to the next window.
          edge_cnt_q <= CNT_W'(rise);
          if (enable) begin
            state_q <= ST_MEASURE;
            gate_q  <= GATE_RELOAD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CLK_MON_STICKY_EN
  logic lost_q;
  logic lock_drop;

  assign lock_drop = locked_q & (((state_q == ST_MEASURE) & ~enable) |
                                 ((state_q == ST_REPORT) & ~in_tol));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lost_q <= 1'b0;
    else if (lock_drop) lost_q <= 1'b1;
    else if (lost_clr)  lost_q <= 1'b0;
  end

  assign lost = lost_q;
`else
  logic unused_lost_clr;
  assign unused_lost_clr = lost_clr;
  assign lost            = 1'b0;
`endif

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign in_range    = in_range_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_clk_freq_monitor.sv
// tb/tb_clk_freq_monitor.sv - randomized directed bench for clk_freq_monitor against a window-level model
module tb_clk_freq_monitor;

  localparam int GC  = 64;
  localparam int CW  = 8;
  localparam int EXP = 16;
  localparam int TL  = 1;
  localparam int LW  = 2;
  localparam int WIN = GC + 1;
`ifdef CLK_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          meas_in = 1'b0;
  logic          enable = 1'b0;
  logic          lost_clr = 1'b0;
  logic [CW-1:0] count;
  logic          count_valid;
  logic          in_range;
  logic          locked;
  logic          lost;

  clk_freq_monitor #(
    .GATE_CYCLES  (GC),
    .CNT_W        (CW),
    .EXP_COUNT    (EXP),
    .TOL          (TL),
    .LOCK_WINDOWS (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_in     (meas_in),
    .enable      (enable),
    .count       (count),
    .count_valid (count_valid),
    .in_range    (in_range),
    .locked      (locked),
    .lost        (lost),
    .lost_clr    (lost_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus generator: period 0 means meas_in held at gen_level.
  int gen_period = 0;
  int gen_level  = 0;
  int gen_pos    = 0;
  int gen_hi     = 1;

  // Model: meas_in as seen at the last three edges, and window bookkeeping by edge index.
  int cyc = 0;
  bit p1, p2, p3;
  bit m_active;
  int m_end;
  int m_acc;
  int m_count;
  bit m_cv, m_inr, m_locked, m_lost;
  int m_lockcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_period(input int p);
    gen_period = p;
    gen_pos    = $urandom_range(0, p - 1);
    gen_hi     = $urandom_range(1, p - 1);
  endtask

  task automatic drive_gen();
    if (gen_period == 0) begin
      meas_in = gen_level[0];
    end else begin
      meas_in = (gen_pos < gen_hi);
      gen_pos++;
      if (gen_pos >= gen_period) begin
        gen_pos = 0;
        gen_hi  = $urandom_range(1, gen_period - 1);
      end
    end
  endtask

  task automatic model_reset();
    p1 = 0; p2 = 0; p3 = 0;
    m_active = 0; m_end = 0; m_acc = 0; m_count = 0;
    m_cv = 0; m_inr = 0; m_locked = 0; m_lost = 0; m_lockcnt = 0;
  endtask

  task automatic model_step();
    bit rise;
    bit new_locked;
    int d;
    cyc++;
    rise = p2 & ~p3;
    p3 = p2; p2 = p1; p1 = meas_in;
    m_cv = 0;
    new_locked = m_locked;
    if (!m_active) begin
      if (enable) begin
        m_active = 1;
        m_end    = cyc + WIN;
        m_acc    = 0;
      end
    end else if (cyc == m_end) begin
      m_cv    = 1;
      m_count = m_acc;
      d = m_acc - EXP;
      if (d < 0) d = -d;
      m_inr = (d <= TL);
      if (m_inr) begin
        if (m_lockcnt < LW) m_lockcnt++;
        new_locked = (m_lockcnt >= LW);
      end else begin
        m_lockcnt  = 0;
        new_locked = 0;
      end
      m_acc = rise ? 1 : 0;
      if (enable) m_end = cyc + WIN;
      else        m_active = 0;
    end else if (!enable) begin
      m_active   = 0;
      m_inr      = 0;
      m_lockcnt  = 0;
      new_locked = 0;
    end else if (rise && m_acc < (1 << CW) - 1) begin
      m_acc++;
    end
    if (STICKY && m_locked && !new_locked) m_lost = 1;
    else if (lost_clr)                     m_lost = 0;
    m_locked = new_locked;
  endtask

  task automatic tick();
    drive_gen();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("count_valid", count_valid, m_cv);
    check("count", count, m_count);
    check("in_range", in_range, m_inr);
    check("locked", locked, m_locked);
    check("lost", lost, m_lost);
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (count_valid !== 1'b1 && n < budget);
    check("pulse_within_budget", count_valid, 1);
  endtask

  int n;
  logic [CW-1:0] saved;

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_count_valid", count_valid, 0);
    check("rst_locked", locked, 0);
    rst_n = 1'b1;

    // Nominal frequency: every window in tolerance, lock on the second report.
    set_period(4);
    enable = 1'b1;
    wait_pulse(80, n);
    check("t1_first_latency", n, WIN + 1);
    check("t1_count_band", (count >= 16 && count <= 17), 1);
    check("t1_not_locked_yet", locked, 0);
    wait_pulse(80, n);
    check("t1_period", n, WIN);
    check("t1_in_range", in_range, 1);
    check("t1_locked", locked, 1);

    // Half frequency: out of range, lock drops on that report.
    set_period(8);
    wait_pulse(80, n);
    check("t2_count_band", (count >= 8 && count <= 10), 1);
    check("t2_in_range", in_range, 0);
    check("t2_locked", locked, 0);
    check("t2_lost", lost, STICKY);

    // Stuck input.
    gen_period = 0;
    gen_level  = 0;
    wait_pulse(80, n);
    wait_pulse(80, n);
    check("t3_count_zero", count, 0);
    check("t3_in_range", in_range, 0);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t3_lost_cleared", lost, 0);

    // Relock, then drop enable mid-window.
    set_period(4);
    repeat (3) wait_pulse(80, n);
    check("t4_relocked", locked, 1);
    repeat ($urandom_range(5, 40)) tick();
    saved  = count;
    enable = 1'b0;
    tick();
    check("t4_locked_drop", locked, 0);
    check("t4_count_hold", count, saved);
    check("t4_lost_on_drop", lost, STICKY);
    repeat (20) tick();
    check("t4_count_hold_idle", count, saved);
    enable = 1'b1;
    wait_pulse(80, n);
    check("t4_fresh_window", n, WIN + 1);

    // Asynchronous reset between clock edges.
    repeat ($urandom_range(10, 50)) tick();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("t5_async_count", count, 0);
    check("t5_async_count_valid", count_valid, 0);
    check("t5_async_in_range", in_range, 0);
    check("t5_async_locked", locked, 0);
    check("t5_async_lost", lost, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_pulse(80, n);
    check("t5_first_latency", n, WIN + 1);
    repeat (2) wait_pulse(80, n);
    check("t5_relocked", locked, 1);

    // Clear coinciding with a lock loss must not win; a later clear alone does.
    repeat ($urandom_range(5, 40)) tick();
    enable   = 1'b0;
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t6_set_wins", lost, STICKY);
    repeat (3) tick();
    check("t6_still_set", lost, STICKY);
    lost_clr = 1'b1;
    tick();
    lost_clr = 1'b0;
    check("t6_clear", lost, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
